// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Two-port arbiter for the single SRAM controller command bus,
//               with latched commands, done pulses and a completion watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
   parameter int PRIORITY_MODE = 0,
   parameter int TIMEOUT       = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic [31:0] rdata0,
   output logic        done0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic [31:0] rdata1,
   output logic        done1,
   output logic        err,
   output logic        busy,
   output logic        mem_wr_en,
   output logic        mem_rd_en,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_grant;
   logic       r_last_grant;
   logic       r_we;
   logic [7:0] r_cnt;
   logic       w_any_req;
   logic       w_pick1;
   logic       w_sel_we;
   logic       w_finish;

   always_comb begin
      w_any_req = req0 | req1;
      w_pick1   = req1;
      // Tie-break: round-robin favours whoever did not complete last.
      if (req0 && req1) begin
         if (PRIORITY_MODE == 0)
            w_pick1 = ~r_last_grant;
         else
            w_pick1 = 1'b0;
      end
      w_sel_we = w_pick1 ? we1 : we0;
      w_finish = mem_ready || (r_cnt == C_CNT_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
         S_BUSY:  if (w_finish)  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_cnt        <= 8'd0;
         rdata0       <= 32'd0;
         rdata1       <= 32'd0;
         done0        <= 1'b0;
         done1        <= 1'b0;
         err          <= 1'b0;
         busy         <= 1'b0;
         mem_wr_en    <= 1'b0;
         mem_rd_en    <= 1'b0;
         mem_address  <= 32'd0;
         mem_wdata    <= 32'd0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant     <= w_pick1;
                  r_we        <= w_sel_we;
                  mem_address <= w_pick1 ? addr1 : addr0;
                  mem_wdata   <= w_pick1 ? wdata1 : wdata0;
                  mem_wr_en   <= w_sel_we;
                  mem_rd_en   <= ~w_sel_we;
                  r_cnt       <= 8'd0;
                  busy        <= 1'b1;
               end
            end
            S_BUSY: begin
               if (w_finish) begin
                  // Enables fall in DONE so the controller is not retriggered.
                  mem_wr_en <= 1'b0;
                  mem_rd_en <= 1'b0;
                  err       <= ~mem_ready;
                  if (r_grant)
                     done1 <= 1'b1;
                  else
                     done0 <= 1'b1;
                  if (mem_ready && !r_we) begin
                     if (r_grant)
                        rdata1 <= mem_rdata;
                     else
                        rdata0 <= mem_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DONE: begin
               busy         <= 1'b0;
               r_last_grant <= r_grant;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
